scene_loader: RTL and testbench
===============================

# scene_loader

Upstream feeder for `physics_engine`: receives a byte stream from the host UART receiver, assembles a complete scene (per-sprite location, velocity, mass, radius) into shadow registers, verifies an XOR checksum, then atomically commits the scene to the `init_*` outputs. It pulses `data_ready` for one cycle so the engine reloads its state. Malformed or stalled frames are discarded without disturbing the last committed scene.

## Interface
- `SPRITES`, 9, number of sprite records per frame
- `WIDTH`, 32, location/velocity component width; mass is WIDTH/2
- `DIMENSIONS`, 2, components per location/velocity
- `TIMEOUT`, 1_620_000, max idle cycles between bytes inside a frame (10 ms at 162 MHz)
- `clk_162`  in  1  system clock
- `rst_l`  in  1  reset; asynchronous, active-low
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` valid this cycle
- `rx_ready`  out  1  loader accepts a byte; a byte transfers on an edge where `rx_valid & rx_ready`
- `init_locations`  out  SPRITES×DIMENSIONS×WIDTH  committed locations
- `init_velos`  out  SPRITES×DIMENSIONS×WIDTH  committed velocities
- `masses`  out  SPRITES×WIDTH/2  committed masses
- `radii`  out  SPRITES×7  committed radii
- `data_ready`  out  1  one-cycle commit strobe
- `frame_err`  out  1  one-cycle strobe: checksum mismatch or timeout
- `busy`  out  1  frame in progress (state ≠ IDLE)

## Operation
- Frame layout: sync byte 0xA5, then SPRITES records, then one checksum byte.
- Record layout, all fields MSB-first: loc[0], …, loc[DIMENSIONS-1] (WIDTH/8 bytes each), velo[0], …, velo[DIMENSIONS-1], mass (WIDTH/16 bytes), radius (1 byte; bit 7 ignored). BYTES_PER_SPRITE = 19 at the defaults.
- Checksum: XOR of all record bytes, excluding sync. A frame is good when the checksum byte equals the running XOR.
- States:
  - IDLE: discard bytes ≠ 0xA5. On 0xA5, clear the byte index, XOR and timeout counter, and go to LOAD.
  - LOAD: each accepted byte is written into the shadow field selected by the byte index and XORed into the running sum. After the last record byte, go to CSUM. A 0xA5 byte here is treated as data.
  - CSUM: the next accepted byte is compared with the running XOR; go to COMMIT.
  - COMMIT: `rx_ready` = 0. On match, copy shadow to outputs and pulse `data_ready`; on mismatch, pulse `frame_err` and leave outputs unchanged. Return to IDLE.
- `rx_ready` = 1 in IDLE, LOAD and CSUM.
- Timeout: in LOAD or CSUM, the counter increments on every cycle without a transfer and resets on each transfer. When it reaches TIMEOUT-1 with no transfer that cycle, pulse `frame_err` and go to IDLE.
- Simultaneous transfer and timeout terminal count: the transfer wins and the counter resets.
- Shadow registers are written only in LOAD and are never exposed until COMMIT with a good checksum. A partially received frame therefore never reaches the outputs.
- Reset mid-frame: all state and outputs return to reset values immediately (asynchronous). A previously committed scene is lost.
- Reset values: `init_locations`, `init_velos`, `masses`, `radii` = 0; `data_ready` = 0; `frame_err` = 0; `busy` = 0; `rx_ready` = 1; state IDLE.

## Timing
- All outputs are registered except `rx_ready` and `busy`, which decode the state register.
- Edge N accepts the checksum byte (state → COMMIT). Edge N+1 updates `init_*` and raises `data_ready`. `data_ready` is high for exactly the cycle after edge N+1, and `init_*` are already stable in that cycle.
- A sync byte may be accepted on edge N+2 at the earliest.
- Full frame at the defaults: 1 + 171 + 1 = 173 transfers, plus one COMMIT cycle.
- `frame_err` on timeout is high for the cycle after the edge that detects the terminal count.
- Back-to-back bytes (`rx_valid` held high) are accepted one per cycle with no bubbles, except the single COMMIT cycle.

## Structure
- `physics_pkg`:
  - `SYNC_BYTE` = 8'hA5
  - state enum `loader_state_t` {IDLE, LOAD, CSUM, COMMIT}
  - function `bytes_per_sprite(WIDTH, DIMENSIONS)`
- Sub-module `sprite_shadow_regs`: takes byte index and byte, decodes sprite/field/byte position, and holds the shadow arrays in the output-port shapes.
- The loader top holds the FSM, XOR, timeout counter and commit registers.

## Test plan
- Good frame, SPRITES=2: sprite0 loc=(0x00010000, 0xFFFF0000), velo=(0x10, 0), mass=0x0100, radius=0x8A; sprite1 all 0x11 bytes; correct checksum. Required response: `data_ready` pulses once, one cycle after the checksum edge; outputs match, with radius[0] = 7'h0A.
- Same frame with checksum XOR 0x01: `frame_err` pulses once; `data_ready` stays 0; outputs keep the prior scene.
- Garbage bytes 0x00, 0x5A, 0xFF before 0xA5, then a good frame: garbage is ignored and the frame commits normally.
- TIMEOUT=16, frame stalls after 5 record bytes: `frame_err` pulses 16 cycles after the last transfer; `busy` drops.
- Next frame after the timeout commits correctly (no stale index or XOR).
- Payload byte 0xA5 inside a record: treated as data and the frame commits. `rst_l` pulled low mid-LOAD: all outputs go to 0 immediately and state is IDLE.
- Two good frames back-to-back with `rx_valid` held high: exactly one bubble (COMMIT) between frames, and two `data_ready` pulses.

Source files
------------

// File: rtl/physics_pkg.sv
// Shared types and constants for the scene loader and its shadow register file.
package physics_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CSUM,
        COMMIT
    } loader_state_t;

    // Record = locations, velocities, mass (WIDTH/2 bits), one radius byte
    function automatic int unsigned bytes_per_sprite(input int unsigned width,
                                                     input int unsigned dims);
        return 2 * dims * (width / 8) + width / 16 + 1;
    endfunction

endpackage

// File: rtl/sprite_shadow_regs.sv
// Shadow copy of a scene being received: one byte is written per cycle at the
// field position selected by the sprite index and the byte offset in its record.
module sprite_shadow_regs
    import physics_pkg::*;
#(
    parameter int unsigned SPRITES    = 9,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIMENSIONS = 2,
    localparam int unsigned BPS       = bytes_per_sprite(WIDTH, DIMENSIONS),
    localparam int unsigned SPR_W     = (SPRITES > 1) ? $clog2(SPRITES) : 1,
    localparam int unsigned OFF_W     = $clog2(BPS)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                we_i,
    input  logic [SPR_W-1:0]                    sprite_i,
    input  logic [OFF_W-1:0]                    off_i,
    input  logic [7:0]                          byte_i,
    output logic [SPRITES*DIMENSIONS*WIDTH-1:0] loc_o,
    output logic [SPRITES*DIMENSIONS*WIDTH-1:0] velo_o,
    output logic [SPRITES*(WIDTH/2)-1:0]        mass_o,
    output logic [SPRITES*7-1:0]                radius_o
);

    localparam int unsigned WB     = WIDTH / 8;
    localparam int unsigned MB     = WIDTH / 16;
    localparam int unsigned MW     = WIDTH / 2;
    localparam int unsigned V_OFF  = DIMENSIONS * WB;
    localparam int unsigned M_OFF  = 2 * DIMENSIONS * WB;
    localparam int unsigned R_OFF  = M_OFF + MB;

    // Fields arrive MSB-first, so byte b of a field lands in lane (bytes-1-b)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loc_o    <= '0;
            velo_o   <= '0;
            mass_o   <= '0;
            radius_o <= '0;
        end else if (we_i) begin
            for (int s = 0; s < SPRITES; s++) begin
                if (sprite_i == SPR_W'(s)) begin
                    for (int d = 0; d < DIMENSIONS; d++) begin
                        for (int b = 0; b < WB; b++) begin
                            if (off_i == OFF_W'(d * WB + b))
                                loc_o[(s*DIMENSIONS+d)*WIDTH + (WB-1-b)*8 +: 8] <= byte_i;
                            if (off_i == OFF_W'(V_OFF + d * WB + b))
                                velo_o[(s*DIMENSIONS+d)*WIDTH + (WB-1-b)*8 +: 8] <= byte_i;
                        end
                    end
                    for (int b = 0; b < MB; b++) begin
                        if (off_i == OFF_W'(M_OFF + b))
                            mass_o[s*MW + (MB-1-b)*8 +: 8] <= byte_i;
                    end
                    if (off_i == OFF_W'(R_OFF))
                        radius_o[s*7 +: 7] <= byte_i[6:0];
                end
            end
        end
    end

endmodule

// File: rtl/scene_loader.sv
// Assembles a checksummed scene from a host byte stream and atomically commits
// it to the physics engine's init_* inputs, strobing data_ready on success.
module scene_loader
    import physics_pkg::*;
#(
    parameter int unsigned SPRITES    = 9,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIMENSIONS = 2,
    parameter int unsigned TIMEOUT    = 1_620_000
) (
    input  logic                                clk_162,
    input  logic                                rst_l,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_valid,
    output logic                                rx_ready,
    output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_locations,
    output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_velos,
    output logic [SPRITES*(WIDTH/2)-1:0]        masses,
    output logic [SPRITES*7-1:0]                radii,
    output logic                                data_ready,
    output logic                                frame_err,
    output logic                                busy
);

    localparam int unsigned BPS   = bytes_per_sprite(WIDTH, DIMENSIONS);
    localparam int unsigned SPR_W = (SPRITES > 1) ? $clog2(SPRITES) : 1;
    localparam int unsigned OFF_W = $clog2(BPS);
    localparam int unsigned TO_W  = $clog2(TIMEOUT);

    loader_state_t    state_q, state_d;
    logic [SPR_W-1:0] spr_q, spr_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [7:0]       xor_q, xor_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic             csum_ok_q, csum_ok_d;
    logic             data_ready_q, data_ready_d;
    logic             frame_err_q, frame_err_d;
    logic             xfer_c;
    logic             timeout_c;

    logic [SPRITES*DIMENSIONS*WIDTH-1:0] sh_loc;
    logic [SPRITES*DIMENSIONS*WIDTH-1:0] sh_velo;
    logic [SPRITES*(WIDTH/2)-1:0]        sh_mass;
    logic [SPRITES*7-1:0]                sh_radius;

    assign rx_ready   = (state_q != COMMIT);
    assign busy       = (state_q != IDLE);
    assign xfer_c     = rx_valid & rx_ready;
    assign timeout_c  = (cnt_q == TO_W'(TIMEOUT - 1));
    assign data_ready = data_ready_q;
    assign frame_err  = frame_err_q;

    sprite_shadow_regs #(
        .SPRITES    (SPRITES),
        .WIDTH      (WIDTH),
        .DIMENSIONS (DIMENSIONS)
    ) u_shadow (
        .clk      (clk_162),
        .rst_n    (rst_l),
        .we_i     (xfer_c && (state_q == LOAD)),
        .sprite_i (spr_q),
        .off_i    (off_q),
        .byte_i   (rx_data),
        .loc_o    (sh_loc),
        .velo_o   (sh_velo),
        .mass_o   (sh_mass),
        .radius_o (sh_radius)
    );

    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= IDLE;
            spr_q        <= '0;
            off_q        <= '0;
            xor_q        <= '0;
            cnt_q        <= '0;
            csum_ok_q    <= 1'b0;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            spr_q        <= spr_d;
            off_q        <= off_d;
            xor_q        <= xor_d;
            cnt_q        <= cnt_d;
            csum_ok_q    <= csum_ok_d;
            data_ready_q <= data_ready_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // A transfer always beats the timeout terminal count in the same cycle
    always_comb begin
        state_d      = state_q;
        spr_d        = spr_q;
        off_d        = off_q;
        xor_d        = xor_q;
        cnt_d        = cnt_q;
        csum_ok_d    = csum_ok_q;
        data_ready_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer_c && (rx_data == SYNC_BYTE)) begin
                    spr_d   = '0;
                    off_d   = '0;
                    xor_d   = '0;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (xfer_c) begin
                    xor_d = xor_q ^ rx_data;
                    cnt_d = '0;
                    if (off_q == OFF_W'(BPS - 1)) begin
                        off_d = '0;
                        if (spr_q == SPR_W'(SPRITES - 1))
                            state_d = CSUM;
                        else
                            spr_d = spr_q + SPR_W'(1);
                    end else begin
                        off_d = off_q + OFF_W'(1);
                    end
                end else if (timeout_c) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            CSUM: begin
                if (xfer_c) begin
                    csum_ok_d = (rx_data == xor_q);
                    state_d   = COMMIT;
                end else if (timeout_c) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            COMMIT: begin
                data_ready_d = csum_ok_q;
                frame_err_d  = !csum_ok_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Committed scene only changes on a verified frame
    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) begin
            init_locations <= '0;
            init_velos     <= '0;
            masses         <= '0;
            radii          <= '0;
        end else if ((state_q == COMMIT) && csum_ok_q) begin
            init_locations <= sh_loc;
            init_velos     <= sh_velo;
            masses         <= sh_mass;
            radii          <= sh_radius;
        end
    end

endmodule

// File: tb/tb_scene_loader.sv
// Directed bench for scene_loader with two sprites and a short timeout.
module tb_scene_loader;

    localparam int unsigned SP = 2;
    localparam int unsigned W  = 32;
    localparam int unsigned D  = 2;
    localparam int unsigned TO = 16;

    logic              clk_162;
    logic              rst_l;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [SP*D*W-1:0] init_locations;
    logic [SP*D*W-1:0] init_velos;
    logic [SP*W/2-1:0] masses;
    logic [SP*7-1:0]   radii;
    logic              data_ready;
    logic              frame_err;
    logic              busy;

    int passes  = 0;
    int total   = 0;
    int bubbles = 0;
    int dr_cnt  = 0;
    int fe_cnt  = 0;
    int dr_base;
    int fe_base;

    logic [7:0] fa[$];
    logic [7:0] fb[$];
    logic [7:0] tx_q[$];

    localparam logic [127:0] A_LOC  = 128'h11111111_11111111_FFFF0000_00010000;
    localparam logic [127:0] A_VELO = 128'h11111111_11111111_00000000_00000010;
    localparam logic [31:0]  A_MASS = 32'h1111_0100;
    localparam logic [13:0]  A_RAD  = 14'h088A;
    localparam logic [127:0] B_LOC  = 128'h33333333_33333333_22222222_A5222222;
    localparam logic [127:0] B_VELO = 128'h33333333_33333333_22222222_22222222;
    localparam logic [31:0]  B_MASS = 32'h3333_2222;
    localparam logic [13:0]  B_RAD  = 14'h19A2;

    scene_loader #(
        .SPRITES    (SP),
        .WIDTH      (W),
        .DIMENSIONS (D),
        .TIMEOUT    (TO)
    ) dut (
        .clk_162        (clk_162),
        .rst_l          (rst_l),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .init_locations (init_locations),
        .init_velos     (init_velos),
        .masses         (masses),
        .radii          (radii),
        .data_ready     (data_ready),
        .frame_err      (frame_err),
        .busy           (busy)
    );

    initial clk_162 = 1'b0;
    always #5 clk_162 = ~clk_162;

    always @(negedge clk_162) begin
        if (data_ready === 1'b1) dr_cnt++;
        if (frame_err === 1'b1)  fe_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents tx_q one byte per cycle, holding rx_valid while stalled
    task automatic send_q();
        int guard;
        bubbles = 0;
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge clk_162);
            rx_data  = tx_q[i];
            rx_valid = 1'b1;
            guard    = 0;
            while (!rx_ready && guard < 8) begin
                guard++;
                @(negedge clk_162);
            end
            bubbles += guard;
        end
        @(negedge clk_162);
        rx_valid = 1'b0;
    endtask

    task automatic chk_scene(input string tag, input logic [127:0] loc, input logic [127:0] velo,
                             input logic [31:0] mass, input logic [13:0] rad);
        chk({tag, "_loc"}, 128'(init_locations), loc);
        chk({tag, "_velo"}, 128'(init_velos), velo);
        chk({tag, "_mass"}, 128'(masses), 128'(mass));
        chk({tag, "_rad"}, 128'(radii), 128'(rad));
    endtask

    initial begin
        fa = '{8'hA5,
               8'h00, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h00, 8'h8A};
        for (int i = 0; i < 19; i++) fa.push_back(8'h11);
        fa.push_back(8'h8B);
        fb = '{8'hA5, 8'hA5};
        for (int i = 0; i < 18; i++) fb.push_back(8'h22);
        for (int i = 0; i < 19; i++) fb.push_back(8'h33);
        fb.push_back(8'h96);

        rst_l    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk_162);
        chk_scene("reset", 128'h0, 128'h0, 32'h0, 14'h0);
        chk("reset_dr", 128'(data_ready), 128'h0);
        chk("reset_fe", 128'(frame_err), 128'h0);
        chk("reset_busy", 128'(busy), 128'h0);
        chk("reset_rdy", 128'(rx_ready), 128'h1);
        rst_l = 1'b1;
        @(negedge clk_162);

        // Good frame A, then commit timing
        dr_base = dr_cnt;
        tx_q = fa;
        send_q();
        chk("a_bubbles", 128'(bubbles), 128'h0);
        chk("a_commit_rdy", 128'(rx_ready), 128'h0);
        chk("a_commit_dr", 128'(data_ready), 128'h0);
        @(negedge clk_162);
        chk("a_dr_high", 128'(data_ready), 128'h1);
        chk("a_busy", 128'(busy), 128'h0);
        chk_scene("a", A_LOC, A_VELO, A_MASS, A_RAD);
        @(negedge clk_162);
        chk("a_dr_low", 128'(data_ready), 128'h0);
        chk("a_dr_once", 128'(dr_cnt - dr_base), 128'h1);

        // Frame B with corrupted checksum: error, scene A kept
        dr_base = dr_cnt;
        fe_base = fe_cnt;
        tx_q = fb;
        tx_q[tx_q.size()-1] = 8'h97;
        send_q();
        @(negedge clk_162);
        chk("bad_fe_high", 128'(frame_err), 128'h1);
        chk("bad_dr", 128'(data_ready), 128'h0);
        @(negedge clk_162);
        chk("bad_fe_low", 128'(frame_err), 128'h0);
        chk("bad_fe_once", 128'(fe_cnt - fe_base), 128'h1);
        chk("bad_no_dr", 128'(dr_cnt - dr_base), 128'h0);
        chk_scene("bad_keep", A_LOC, A_VELO, A_MASS, A_RAD);

        // Garbage then frame B (payload contains 0xA5)
        dr_base = dr_cnt;
        tx_q = '{8'h00, 8'h5A, 8'hFF};
        tx_q = {tx_q, fb};
        send_q();
        repeat (2) @(negedge clk_162);
        chk("garb_dr_once", 128'(dr_cnt - dr_base), 128'h1);
        chk_scene("garb_b", B_LOC, B_VELO, B_MASS, B_RAD);

        // Stall after 5 record bytes
        fe_base = fe_cnt;
        tx_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_q();
        repeat (15) @(negedge clk_162);
        chk("to_pre_fe", 128'(frame_err), 128'h0);
        chk("to_pre_busy", 128'(busy), 128'h1);
        @(negedge clk_162);
        chk("to_fe", 128'(frame_err), 128'h1);
        chk("to_busy", 128'(busy), 128'h0);
        @(negedge clk_162);
        chk("to_fe_low", 128'(frame_err), 128'h0);
        chk("to_fe_once", 128'(fe_cnt - fe_base), 128'h1);
        chk_scene("to_keep", B_LOC, B_VELO, B_MASS, B_RAD);

        // Recovery after timeout
        tx_q = fa;
        send_q();
        repeat (2) @(negedge clk_162);
        chk_scene("recov_a", A_LOC, A_VELO, A_MASS, A_RAD);

        // Back-to-back B then A with rx_valid held
        dr_base = dr_cnt;
        tx_q = {fb, fa};
        send_q();
        chk("b2b_bubbles", 128'(bubbles), 128'h1);
        repeat (2) @(negedge clk_162);
        chk("b2b_dr_twice", 128'(dr_cnt - dr_base), 128'h2);
        chk_scene("b2b_a", A_LOC, A_VELO, A_MASS, A_RAD);

        // Reset mid-LOAD
        tx_q = '{8'hA5, 8'h01, 8'h02, 8'h03};
        send_q();
        chk("rst_pre_busy", 128'(busy), 128'h1);
        #2 rst_l = 1'b0;
        #1;
        chk_scene("rst_mid", 128'h0, 128'h0, 32'h0, 14'h0);
        chk("rst_mid_busy", 128'(busy), 128'h0);
        chk("rst_mid_rdy", 128'(rx_ready), 128'h1);
        chk("rst_mid_dr", 128'(data_ready), 128'h0);
        @(negedge clk_162);
        rst_l = 1'b1;
        tx_q = fb;
        send_q();
        repeat (2) @(negedge clk_162);
        chk_scene("post_rst_b", B_LOC, B_VELO, B_MASS, B_RAD);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
